// File: rtl/mc_ctrl_pkg.sv
// Shared encodings and data-processing decode for the multicycle control unit.
// Long multiplies (UMULL/SMULL) are decoded only when MC_MUL_LONG_EN is defined.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExecuteR,
    StExecuteI,
    StAluWb,
    StBranch
  } state_e;

`ifdef MC_MUL_LONG_EN
  localparam bit LongMulEn = 1'b1;
`else
  localparam bit LongMulEn = 1'b0;
`endif

  localparam logic [2:0] AluAdd   = 3'b000;
  localparam logic [2:0] AluSub   = 3'b001;
  localparam logic [2:0] AluAnd   = 3'b010;
  localparam logic [2:0] AluOrr   = 3'b011;
  localparam logic [2:0] AluMul   = 3'b100;
  localparam logic [2:0] AluUmull = 3'b101;
  localparam logic [2:0] AluSmull = 3'b110;

  localparam logic [1:0] SrcBReg  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] ImmRot8   = 2'b00;
  localparam logic [1:0] ImmOff12  = 2'b01;
  localparam logic [1:0] ImmBranch = 2'b10;

  localparam logic [1:0] OpDp     = 2'b00;
  localparam logic [1:0] OpMem    = 2'b01;
  localparam logic [1:0] OpBranch = 2'b10;

  localparam logic [3:0] CmdAnd   = 4'b0000;
  localparam logic [3:0] CmdSub   = 4'b0010;
  localparam logic [3:0] CmdAdd   = 4'b0100;
  localparam logic [3:0] CmdSmull = 4'b0110;
  localparam logic [3:0] CmdCmp   = 4'b1010;
  localparam logic [3:0] CmdOrr   = 4'b1100;

  localparam logic [3:0] MulTagCode = 4'b1001;

  localparam logic [3:0] CondEq = 4'b0000;
  localparam logic [3:0] CondNe = 4'b0001;
  localparam logic [3:0] CondCs = 4'b0010;
  localparam logic [3:0] CondCc = 4'b0011;
  localparam logic [3:0] CondMi = 4'b0100;
  localparam logic [3:0] CondPl = 4'b0101;
  localparam logic [3:0] CondVs = 4'b0110;
  localparam logic [3:0] CondVc = 4'b0111;
  localparam logic [3:0] CondHi = 4'b1000;
  localparam logic [3:0] CondLs = 4'b1001;
  localparam logic [3:0] CondGe = 4'b1010;
  localparam logic [3:0] CondLt = 4'b1011;
  localparam logic [3:0] CondGt = 4'b1100;
  localparam logic [3:0] CondLe = 4'b1101;
  localparam logic [3:0] CondAl = 4'b1110;

  typedef struct packed {
    logic       valid;
    logic [2:0] alu;
    logic       is_logic;
    logic       is_cmp;
    logic       is_long;
  } dp_dec_t;

  // Multiplies only exist in the register form (Funct[5]=0).
  function automatic dp_dec_t dp_decode(logic [5:0] funct, logic [3:0] multag);
    dp_dec_t    d;
    logic [3:0] cmd;
    cmd        = funct[4:1];
    d.valid    = 1'b1;
    d.alu      = AluAdd;
    d.is_logic = 1'b0;
    d.is_cmp   = 1'b0;
    d.is_long  = 1'b0;
    if (multag == MulTagCode && !funct[5]) begin
      unique case (cmd)
        CmdAnd:   d.alu = AluMul;
        CmdAdd:   begin d.alu = AluUmull; d.is_long = 1'b1; end
        CmdSmull: begin d.alu = AluSmull; d.is_long = 1'b1; end
        default:  d.valid = 1'b0;
      endcase
      if (d.is_long && !LongMulEn) d.valid = 1'b0;
    end else begin
      unique case (cmd)
        CmdAdd:  d.alu = AluAdd;
        CmdSub:  d.alu = AluSub;
        CmdCmp:  begin d.alu = AluSub; d.is_cmp = 1'b1; end
        CmdAnd:  begin d.alu = AluAnd; d.is_logic = 1'b1; end
        CmdOrr:  begin d.alu = AluOrr; d.is_logic = 1'b1; end
        default: d.valid = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/mc_cond_unit.sv
// Combinational ARM condition-code check against a stored NZCV flag set.
module mc_cond_unit
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       condex_o
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags_i;

  // 1111 falls into the default and is treated as never-execute.
  always_comb begin
    condex_o = 1'b0;
    unique case (cond_i)
      CondEq:  condex_o = z;
      CondNe:  condex_o = !z;
      CondCs:  condex_o = c;
      CondCc:  condex_o = !c;
      CondMi:  condex_o = n;
      CondPl:  condex_o = !n;
      CondVs:  condex_o = v;
      CondVc:  condex_o = !v;
      CondHi:  condex_o = c && !z;
      CondLs:  condex_o = !c || z;
      CondGe:  condex_o = (n == v);
      CondLt:  condex_o = (n != v);
      CondGt:  condex_o = !z && (n == v);
      CondLe:  condex_o = z || (n != v);
      CondAl:  condex_o = 1'b1;
      default: condex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Moore control FSM for the multicycle ARM-subset datapath, with NZCV flag storage.
// Defining MC_MUL_LONG_EN enables UMULL/SMULL and the RegWriteHi strobe.
module mc_controller
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] MulTag,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       RegWriteHi,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] RegSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl
);

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       condex_q, condex_d;
  logic       condex;
  dp_dec_t    dec;
  logic       dp_ok;
  logic       pcw, mw, rw, irw;

  assign dec = dp_decode(Funct, MulTag);
  // Long multiplies write Rd and Rd+1, so Rd must leave room below R14.
  assign dp_ok = dec.valid && !(dec.is_long && (Rd >= 4'd14));

  mc_cond_unit u_cond (
    .cond_i   (Cond),
    .flags_i  (flags_q),
    .condex_o (condex)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StFetch;
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    flags_d  = flags_q;
    condex_d = condex_q;
    unique case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        condex_d = condex;
        unique case (Op)
          OpDp: begin
            if (!dp_ok)        state_d = StFetch;
            else if (Funct[5]) state_d = StExecuteI;
            else               state_d = StExecuteR;
          end
          OpMem:    state_d = StMemAdr;
          OpBranch: state_d = StBranch;
          default:  state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = Funct[0] ? StMemRd : StMemWr;
      StMemRd:  state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  state_d = StFetch;
      StExecuteR, StExecuteI: begin
        // Logic ops have no carry/overflow meaning, so C and V survive them.
        if (Funct[0] && condex_q) begin
          flags_d = dec.is_logic ? {ALUFlags[3:2], flags_q[1:0]} : ALUFlags;
        end
        state_d = dec.is_cmp ? StFetch : StAluWb;
      end
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    pcw        = 1'b0;
    mw         = 1'b0;
    rw         = 1'b0;
    irw        = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SrcBReg;
    ResultSrc  = ResAluOut;
    ALUControl = AluAdd;
    RegSrc     = {Op == OpMem, Op == OpBranch};
    unique case (Op)
      OpMem:    ImmSrc = ImmOff12;
      OpBranch: ImmSrc = ImmBranch;
      default:  ImmSrc = ImmRot8;
    endcase
    unique case (state_q)
      StFetch: begin
        irw       = 1'b1;
        pcw       = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluResult;
      end
      StDecode: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluResult;
      end
      StMemAdr: ALUSrcB = SrcBImm;
      StMemRd:  AdrSrc = 1'b1;
      StMemWb: begin
        ResultSrc = ResData;
        rw        = condex_q;
        pcw       = condex_q && (Rd == 4'd15);
      end
      StMemWr: begin
        AdrSrc = 1'b1;
        mw     = condex_q;
      end
      StExecuteR: ALUControl = dec.alu;
      StExecuteI: begin
        ALUSrcB    = SrcBImm;
        ALUControl = dec.alu;
      end
      StAluWb: begin
        // Keep the EXECUTE operand selects so the high product is still valid.
        ALUSrcB    = Funct[5] ? SrcBImm : SrcBReg;
        ALUControl = dec.alu;
        rw         = condex_q;
        pcw        = condex_q && (Rd == 4'd15);
      end
      StBranch: begin
        ALUSrcB   = SrcBImm;
        ResultSrc = ResAluResult;
        pcw       = condex_q;
      end
      default: ;
    endcase
  end

  assign PCWrite  = pcw && !reset;
  assign MemWrite = mw && !reset;
  assign RegWrite = rw && !reset;
  assign IRWrite  = irw && !reset;

`ifdef MC_MUL_LONG_EN
  assign RegWriteHi = (state_q == StAluWb) && condex_q && dec.is_long && !reset;
`else
  assign RegWriteHi = 1'b0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Randomized scoreboard bench for mc_controller: a per-instruction reference model queues
// the expected control word of every cycle, and a negedge monitor compares the DUT against it.
module tb_mc_controller;

  typedef struct packed {
    logic       pcw;
    logic       mw;
    logic       rw;
    logic       rwh;
    logic       irw;
    logic       adr;
    logic [1:0] regsrc;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic [1:0] imm;
    logic [2:0] alu;
  } ctl_t;

  typedef struct {
    ctl_t  v;
    ctl_t  k;
    string tag;
  } exp_t;

`ifdef MC_MUL_LONG_EN
  localparam bit LongEn = 1'b1;
`else
  localparam bit LongEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] Cond = 4'hE;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'd0;
  logic [3:0] Rd = 4'd0;
  logic [3:0] MulTag = 4'd0;
  logic [3:0] ALUFlags = 4'd0;
  logic       PCWrite, MemWrite, RegWrite, RegWriteHi, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] RegSrc, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0] ALUControl;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Cond       (Cond),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .MulTag     (MulTag),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .RegWriteHi (RegWriteHi),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .RegSrc     (RegSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl)
  );

  always #5 clk = ~clk;

  ctl_t       act;
  assign act = {PCWrite, MemWrite, RegWrite, RegWriteHi, IRWrite, AdrSrc, RegSrc, ALUSrcA,
                ALUSrcB, ResultSrc, ImmSrc, ALUControl};

  exp_t       sb[$];
  exp_t       cur;
  int         tests = 0;
  int         fails = 0;
  logic [3:0] flags = 4'b0000;          // model NZCV
  logic [2:0] alu_of[logic [3:0]];       // supported non-multiply commands

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      tests++;
      if (((act ^ cur.v) & cur.k) !== 18'd0) begin
        fails++;
        $display("FAIL %s: got %b required %b (care %b)", cur.tag, act, cur.v, cur.k);
      end
    end
  end

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? !base : base;
  endfunction

  function automatic ctl_t val(input bit pcw, input bit mw, input bit rw, input bit rwh,
                               input bit irw, input bit adr, input logic [1:0] rs,
                               input bit sa, input logic [1:0] sbv, input logic [1:0] res,
                               input logic [1:0] im, input logic [2:0] al);
    return {pcw, mw, rw, rwh, irw, adr, rs, sa, sbv, res, im, al};
  endfunction

  // Strobes are always checked; the flags pick which mux selects matter this cycle.
  function automatic ctl_t care(input bit adr, input bit rs, input bit sa, input bit sbv,
                                input bit res, input bit im, input bit al);
    return {5'b11111, adr, {2{rs}}, sa, {2{sbv}}, {2{res}}, {2{im}}, {3{al}}};
  endfunction

  task automatic issue(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                       input logic [3:0] rd, input logic [3:0] mt, input logic [3:0] af,
                       input int rst_at, input string tag);
    ctl_t       ev[$], kv[$];
    ctl_t       e;
    exp_t       x;
    logic [1:0] rs, im, sbv;
    logic [3:0] cmd;
    logic [2:0] alu;
    bit         ce, ismul, ok, cmp, lgc, lng, wb15, opv;
    int         ra;
    rs    = {op == 2'b01, op == 2'b10};
    im    = op;
    opv   = (op != 2'b11);
    ce    = cond_ok(c, flags);
    cmd   = fn[4:1];
    ismul = (mt == 4'b1001) && !fn[5];
    ok = 1'b0; cmp = 1'b0; lgc = 1'b0; lng = 1'b0; alu = 3'd0;
    ra = rst_at;
    if (op == 2'b00) begin
      if (ismul) begin
        if (cmd == 4'd0) begin
          ok = 1'b1; alu = 3'd4;
        end else if (LongEn && rd < 4'd14 && (cmd == 4'd4 || cmd == 4'd6)) begin
          ok = 1'b1; lng = 1'b1; alu = (cmd == 4'd4) ? 3'd5 : 3'd6;
        end
      end else if (alu_of.exists(cmd)) begin
        ok  = 1'b1;
        alu = alu_of[cmd];
        cmp = (cmd == 4'd10);
        lgc = (cmd == 4'd0) || (cmd == 4'd12);
      end
    end
    wb15 = ce && (rd == 4'd15);
    sbv  = fn[5] ? 2'd1 : 2'd0;
    ev.push_back(val(1, 0, 0, 0, 1, 0, rs, 1, 2'd2, 2'd2, im, 3'd0));
    kv.push_back(care(1, 0, 1, 1, 1, 0, 1));
    ev.push_back(val(0, 0, 0, 0, 0, 0, rs, 1, 2'd2, 2'd2, im, 3'd0));
    kv.push_back(care(0, opv, 1, 1, 1, opv, 1));
    if (op == 2'b01) begin
      ev.push_back(val(0, 0, 0, 0, 0, 0, rs, 0, 2'd1, 2'd0, im, 3'd0));
      kv.push_back(care(0, 0, 1, 1, 0, 0, 1));
      if (fn[0]) begin
        ev.push_back(val(0, 0, 0, 0, 0, 1, rs, 0, 2'd0, 2'd0, im, 3'd0));
        kv.push_back(care(1, 0, 0, 0, 1, 0, 0));
        ev.push_back(val(wb15, 0, ce, 0, 0, 0, rs, 0, 2'd0, 2'd1, im, 3'd0));
        kv.push_back(care(0, 0, 0, 0, 1, 0, 0));
      end else begin
        ev.push_back(val(0, ce, 0, 0, 0, 1, rs, 0, 2'd0, 2'd0, im, 3'd0));
        kv.push_back(care(1, 1, 0, 0, 1, 0, 0));
      end
    end else if (op == 2'b10) begin
      ev.push_back(val(ce, 0, 0, 0, 0, 0, rs, 0, 2'd1, 2'd2, im, 3'd0));
      kv.push_back(care(0, 0, 1, 1, 1, 0, 1));
    end else if (op == 2'b00 && ok) begin
      ev.push_back(val(0, 0, 0, 0, 0, 0, rs, 0, sbv, 2'd0, im, alu));
      kv.push_back(care(0, 0, 1, 1, 0, 0, 1));
      if (!cmp) begin
        ev.push_back(val(wb15, 0, ce, ce && lng, 0, 0, rs, 0, sbv, 2'd0, im, alu));
        kv.push_back(care(0, 0, 1, 1, 1, 0, 1));
      end
    end
    if (ra > ev.size()) ra = 0;
    if (ra > 0) begin
      while (ev.size() > ra) begin
        void'(ev.pop_back());
        void'(kv.pop_back());
      end
      e = ev[ra-1];
      {e.pcw, e.mw, e.rw, e.rwh, e.irw} = 5'b00000;
      ev[ra-1] = e;
    end
    for (int i = 0; i < ev.size(); i++) begin
      x.v   = ev[i];
      x.k   = kv[i];
      x.tag = $sformatf("%s.cyc%0d", tag, i + 1);
      sb.push_back(x);
    end
    Cond = c; Op = op; Funct = fn; Rd = rd; MulTag = mt; ALUFlags = af;
    for (int i = 1; i <= ev.size(); i++) begin
      if (i == ra) reset = 1'b1;
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    if (ra > 0) flags = 4'b0000;
    else if (op == 2'b00 && ok && fn[0] && ce) flags = lgc ? {af[3:2], flags[1:0]} : af;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [3:0] cmds[6];
    logic [3:0] c, rd, mt, af;
    logic [1:0] op;
    logic [5:0] fn;
    int         r, rst;
    cmds = '{4'd0, 4'd2, 4'd4, 4'd6, 4'd10, 4'd12};
    alu_of[4'd4]  = 3'd0;
    alu_of[4'd2]  = 3'd1;
    alu_of[4'd10] = 3'd1;
    alu_of[4'd0]  = 3'd2;
    alu_of[4'd12] = 3'd3;

    // Reset held: FETCH selects visible, every write strobe suppressed.
    @(posedge clk);
    #1;
    cur.v   = val(0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd2, 2'd2, 2'd0, 3'd0);
    cur.k   = care(1, 0, 1, 1, 1, 0, 1);
    cur.tag = "reset";
    sb.push_back(cur);
    @(posedge clk);
    #1;
    reset = 1'b0;

    issue(4'hE, 2'b00, 6'b001000, 4'd1, 4'd0, 4'h0, 0, "add_r1");
    issue(4'hE, 2'b01, 6'b011001, 4'd4, 4'd0, 4'h0, 0, "ldr_r4");
    issue(4'hE, 2'b01, 6'b011000, 4'd4, 4'd0, 4'h0, 0, "str_r4");
    issue(4'hE, 2'b00, 6'b000101, 4'd0, 4'd0, 4'b0110, 0, "subs_z1");
    issue(4'h0, 2'b10, 6'b000000, 4'd0, 4'd0, 4'h0, 0, "beq_taken");
    issue(4'hE, 2'b00, 6'b000101, 4'd0, 4'd0, 4'b0010, 0, "subs_z0");
    issue(4'h0, 2'b10, 6'b000000, 4'd0, 4'd0, 4'h0, 0, "beq_not_taken");
    issue(4'hE, 2'b00, 6'b000101, 4'd0, 4'd0, 4'b0100, 0, "subs_z1b");
    issue(4'h1, 2'b00, 6'b001000, 4'd1, 4'd0, 4'h0, 0, "addne_skip");
    issue(4'hE, 2'b00, 6'b010101, 4'd0, 4'd0, 4'b0111, 0, "cmp_zcv");
    issue(4'hE, 2'b01, 6'b011000, 4'd5, 4'd0, 4'h0, 4, "str_reset");
    issue(4'h0, 2'b10, 6'b000000, 4'd0, 4'd0, 4'h0, 0, "beq_after_reset");
    issue(4'h1, 2'b10, 6'b000000, 4'd0, 4'd0, 4'h0, 0, "bne_after_reset");
    issue(4'hE, 2'b00, 6'b000101, 4'd0, 4'd0, 4'b0011, 0, "subs_cv");
    issue(4'hE, 2'b00, 6'b000001, 4'd0, 4'd0, 4'b1000, 0, "ands_keep_cv");
    issue(4'h2, 2'b10, 6'b000000, 4'd0, 4'd0, 4'h0, 0, "bcs_after_ands");
    issue(4'h6, 2'b10, 6'b000000, 4'd0, 4'd0, 4'h0, 0, "bvs_after_ands");
    issue(4'hE, 2'b00, 6'b001000, 4'd15, 4'd0, 4'h0, 0, "add_pc");
    issue(4'hE, 2'b01, 6'b011001, 4'd15, 4'd0, 4'h0, 0, "ldr_pc");
    issue(4'hE, 2'b00, 6'b000000, 4'd3, 4'b1001, 4'h0, 0, "mul");
    issue(4'hE, 2'b00, 6'b001000, 4'd2, 4'b1001, 4'h0, 0, "umull_r2");
    issue(4'hE, 2'b00, 6'b001100, 4'd6, 4'b1001, 4'h0, 0, "smull_r6");
    issue(4'hE, 2'b00, 6'b001000, 4'd14, 4'b1001, 4'h0, 0, "umull_r14");
    issue(4'hE, 2'b11, 6'b000000, 4'd0, 4'd0, 4'h0, 0, "op11");
    issue(4'hF, 2'b00, 6'b001000, 4'd1, 4'd0, 4'h0, 0, "cond_nv");
    issue(4'hE, 2'b00, 6'b101000, 4'd1, 4'b1001, 4'h0, 0, "addi_multag");

    for (int n = 0; n < 400; n++) begin
      c  = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom);
      r  = $urandom_range(0, 9);
      op = (r < 4 || r == 9) ? 2'b00 : (r < 6) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
      fn = 6'($urandom);
      if ($urandom_range(0, 3) != 0) fn[4:1] = cmds[$urandom_range(0, 5)];
      mt  = ($urandom_range(0, 1) == 0) ? 4'b1001 : 4'($urandom);
      rd  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      af  = 4'($urandom);
      rst = ($urandom_range(0, 24) == 0) ? int'($urandom_range(1, 5)) : 0;
      issue(c, op, fn, rd, mt, af, rst, $sformatf("rand%0d", n));
    end

    repeat (3) @(posedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control unit driving the multicycle ARM-subset datapath.
- Decodes the latched instruction fields and sequences FETCH/DECODE/EXECUTE/writeback through a Moore main FSM.
- Evaluates the condition field against a stored NZCV flags register.
- Emits every datapath control strobe, including the high-half register write for long multiplies.

Parameters:
- None (all encodings are fixed constants in the shared package).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]
- Rd  in  4  Instr[15:12]
- MulTag  in  4  Instr[7:4]; 4'b1001 marks a multiply
- ALUFlags  in  4  NZCV from the ALU, current cycle
- PCWrite  out  1  PC register enable
- MemWrite  out  1  memory write strobe
- RegWrite  out  1  register file port 3 write
- RegWriteHi  out  1  register file port 4 write (Rd+1 ← high product)
- IRWrite  out  1  instruction register enable
- AdrSrc  out  1  0 = PC, 1 = Result
- RegSrc  out  2  [0] RA1 = R15; [1] RA2 = Rd
- ALUSrcA  out  1  0 = A, 1 = PC
- ALUSrcB  out  2  00 = WriteData, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ImmSrc  out  2  00 = imm8, 01 = imm12, 10 = imm24
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL, 101 UMULL, 110 SMULL

Behaviour:
- Reset and output style:
  - Reset forces state to FETCH, clears flags_q and condex_q.
  - While reset is high, PCWrite, IRWrite, MemWrite, RegWrite and RegWriteHi are forced to 0.
  - All other outputs are Moore outputs of the state register. Reset mid-instruction abandons it with no writes.
- FETCH:
  - AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1.
  - Next state: DECODE.
- DECODE:
  - ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10; this makes R15 read as PC+8.
  - RegSrc and ImmSrc are driven from Op.
  - condex_q ← CondEx(Cond, flags_q). Cond=1110 is always true; 1111 is treated as false.
- DECODE transitions:
  - Op=01 → MEMADR.
  - Op=10 → BRANCH.
  - Op=00 with Funct[5]=1 → EXECUTEI.
  - Op=00, Funct[5]=0 → EXECUTER.
  - Any unsupported cmd or Op=11 → FETCH, with no side effects.
- MEMADR:
  - ALUSrcA=0, ALUSrcB=01, ADD.
  - Next state: Funct[0] ? MEMRD : MEMWR.
- MEMRD:
  - AdrSrc=1, ResultSrc=00.
  - Next state: MEMWB.
- MEMWB:
  - ResultSrc=01, RegWrite=condex_q.
  - Next state: FETCH.
- MEMWR:
  - AdrSrc=1, ResultSrc=00, MemWrite=condex_q.
  - Next state: FETCH.
- EXECUTER / EXECUTEI:
  - ALUSrcA=0; ALUSrcB = 00 (EXECUTER) or 01 (EXECUTEI).
  - ALUControl decoded from Funct[4:1]: 0100 ADD, 0010 SUB, 1010 CMP (uses SUB), 0000 AND, 1100 ORR.
  - Multiply is decoded when MulTag=1001 in EXECUTER only: cmd 0000 → MUL.
  - Flag update: if Funct[0]=1 and condex_q, flags_q ← ALUFlags at the end of this cycle.
  - Logic ops update N and Z only; C and V are retained.
  - Next state: ALUWB, or FETCH for CMP.
- ALUWB:
  - ResultSrc=00, RegWrite=condex_q.
  - ALUSrcA, ALUSrcB and ALUControl hold their EXECUTE values so the combinational high product stays valid.
- BRANCH:
  - ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=condex_q.
  - Next state: FETCH.
- Rd=15 writeback: in MEMWB and ALUWB, if Rd=15, PCWrite=condex_q as well.
- Latencies: data-processing 4 cycles, CMP 3, LDR 5, STR 4, B 3.

Optional Feature:
- Macro: MC_MUL_LONG_EN.
- Defined:
  - cmd 0100 with MulTag=1001 → UMULL; cmd 0110 with MulTag=1001 → SMULL.
  - ALUWB asserts RegWriteHi=condex_q alongside RegWrite.
  - Rd=14 or 15 is treated as an unsupported instruction (DECODE → FETCH).
- Undefined:
  - Long multiplies are unsupported (DECODE → FETCH).
  - RegWriteHi is tied to 0.

Decomposition:
- Package mc_ctrl_pkg:
  - state enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH.
  - ALUControl codes, ALUSrcB/ResultSrc/ImmSrc codes, Cond codes.
- Sub-module mc_cond_unit (combinational): Cond and flags in, CondEx out.
- flags_q and condex_q live in the parent.

Test Plan:
- ADD R1,R2,R3 with R2=5, R3=7: 4 cycles; RegWrite pulses in ALUWB; R1=12; IRWrite seen exactly once.
- LDR R4,[R0,#8] followed by STR: LDR has RegWrite in cycle 5 with ResultSrc=01; STR has MemWrite in cycle 4 with AdrSrc=1 and RegSrc[1]=1.
- SUBS R0,R0,R0 then BEQ +8: flags_q Z=1; the branch has PCWrite in BRANCH; with Z=0, BRANCH has PCWrite=0 and the next fetch is PC+4.
- Conditional ADDNE with Z=1: no RegWrite in ALUWB; state returns to FETCH after 4 cycles.
- Reset asserted in MEMWR: no MemWrite pulse; the next state is FETCH; flags_q=0.
- UMULL R2 with 0xFFFFFFFF·2 (MC_MUL_LONG_EN): ALUWB asserts RegWrite and RegWriteHi together; R2=0xFFFFFFFE, R3=1. Without the macro: no writes, and DECODE → FETCH.
